// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and constant helpers for pipe_addsub
package addsub_pkg;

   localparam int MAX_W = 1024;

   function automatic int chunk_w(input int width, input int stages);
      return width / stages;
   endfunction

   function automatic logic [MAX_W-1:0] signed_max(input int width);
      logic [MAX_W-1:0] v;
      v = '0;
      for (int i = 0; i < width - 1; i++) v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [MAX_W-1:0] signed_min(input int width);
      logic [MAX_W-1:0] v;
      v = '0;
      v[width-1] = 1'b1;
      return v;
   endfunction

   // Per-stage control payload; operand and partial-sum chunks live in the top's skew/deskew arrays
   typedef struct packed {
      logic valid;
      logic sat;
      logic a_msb;
      logic bp_msb;
   } stage_ctrl_t;

endpackage

// File: rtl/addsub_chunk.sv
// rtl/addsub_chunk.sv - one carry-chain slice with registered sum and carry
module addsub_chunk
   import addsub_pkg::*;
#(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [CW-1:0] a,
   input  logic [CW-1:0] b,
   input  logic          ci,
   output logic [CW-1:0] s,
   output logic          co
);

   logic [CW:0] add_w;

   assign add_w = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, ci};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s  <= '0;
         co <= 1'b0;
      end else if (en) begin
         s  <= add_w[CW-1:0];
         co <= add_w[CW];
      end
   end

endmodule

// File: rtl/pipe_addsub.sv
// rtl/pipe_addsub.sv - pipelined add/sub with stream handshake; ADDSUB_SAT_EN adds a sat port
module pipe_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
`ifdef ADDSUB_SAT_EN
   input  logic             sat,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW  = chunk_w(WIDTH, STAGES);
   localparam int MSB = WIDTH - 1;
   localparam logic [MAX_W-1:0] SMAX_F = signed_max(WIDTH);
   localparam logic [MAX_W-1:0] SMIN_F = signed_min(WIDTH);
   localparam logic [WIDTH-1:0] SMAX   = SMAX_F[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SMIN   = SMIN_F[WIDTH-1:0];

   logic             sat_in;
   logic             adv;
   logic [WIDTH-1:0] bp;
   logic             c0;

   stage_ctrl_t      ctl_q [STAGES];
   logic [WIDTH-1:0] a_sk  [STAGES];
   logic [WIDTH-1:0] bp_sk [STAGES];
   logic [WIDTH-1:0] lo_q  [STAGES];
   logic [WIDTH-1:0] res_w [STAGES];
   logic [CW-1:0]    s_c   [STAGES];
   logic             co_c  [STAGES];

   stage_ctrl_t      ctl_last;
   logic [WIDTH-1:0] sum_raw;

`ifdef ADDSUB_SAT_EN
   assign sat_in = sat;
`else
   assign sat_in = 1'b0;
`endif

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign bp       = sub ? ~b : b;
   assign c0       = sub ? ~cin : cin;

   // Chunk k consumes the operands delayed k cycles and the carry registered by chunk k-1
   for (genvar k = 0; k < STAGES; k++) begin : g_chunk
      logic [CW-1:0] a_in;
      logic [CW-1:0] b_in;
      logic          c_in;

      if (k == 0) begin : g_first
         assign a_in = a[CW-1:0];
         assign b_in = bp[CW-1:0];
         assign c_in = c0;
      end else begin : g_rest
         assign a_in = a_sk[k-1][k*CW +: CW];
         assign b_in = bp_sk[k-1][k*CW +: CW];
         assign c_in = co_c[k-1];
      end

      addsub_chunk #(.CW(CW)) u_chunk (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (adv),
         .a     (a_in),
         .b     (b_in),
         .ci    (c_in),
         .s     (s_c[k]),
         .co    (co_c[k])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            ctl_q[k] <= '0;
            a_sk[k]  <= '0;
            bp_sk[k] <= '0;
            lo_q[k]  <= '0;
         end
      end else begin
         if (adv) begin
            ctl_q[0] <= '{valid: in_valid, sat: sat_in, a_msb: a[MSB], bp_msb: bp[MSB]};
            a_sk[0]  <= a;
            bp_sk[0] <= bp;
            lo_q[0]  <= '0;
            for (int k = 1; k < STAGES; k++) begin
               ctl_q[k] <= ctl_q[k-1];
               a_sk[k]  <= a_sk[k-1];
               bp_sk[k] <= bp_sk[k-1];
               lo_q[k]  <= res_w[k-1];
            end
         end
         // Flush wins over advance: only the valid bits are cleared, data may stay stale
         if (clr) begin
            for (int k = 0; k < STAGES; k++) ctl_q[k].valid <= 1'b0;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         res_w[k] = (k == 0) ? '0 : lo_q[k];
         res_w[k][k*CW +: CW] = s_c[k];
      end
   end

   assign ctl_last  = ctl_q[STAGES-1];
   assign sum_raw   = res_w[STAGES-1];
   assign out_valid = ctl_last.valid;
   assign cout      = co_c[STAGES-1];
   assign ovf       = (ctl_last.a_msb == ctl_last.bp_msb) && (sum_raw[MSB] != ctl_last.a_msb);
   assign sum       = (ctl_last.sat && ovf) ? (ctl_last.a_msb ? SMIN : SMAX) : sum_raw;

endmodule

// File: tb/tb_pipe_addsub.sv
// tb/tb_pipe_addsub.sv - scoreboard bench for pipe_addsub (16/2 directed, 32/4 random)
module tb_pipe_addsub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, clr;

   logic iv16, ir16, ov16, or16, cin16, sub16, co16, ovf16;
   logic [15:0] a16, b16, s16;
   logic iv32, ir32, ov32, or32, cin32, sub32, co32, ovf32;
   logic [31:0] a32, b32, s32;
   logic sat16, sat32;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int stall32 = 0;
   bit mon16_en = 1'b1;

   logic [17:0] q16[$];
   logic [33:0] q32[$];
   int acc_cyc[$];
   int acc_stall[$];

   // directed vectors: a, b, cin, sub, expected {cout, ovf, sum}
   logic [15:0] ta [7] = '{16'h7FFF, 16'h0005, 16'h0005, 16'h1234, 16'h8000, 16'h0007, 16'hFFFF};
   logic [15:0] tb [7] = '{16'h0001, 16'h0007, 16'h0007, 16'h4321, 16'h0001, 16'h0005, 16'hFFFF};
   logic        tc [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
   logic        ts [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   logic [17:0] te [7] = '{{2'b01, 16'h8000}, {2'b00, 16'hFFFE}, {2'b00, 16'hFFFD},
                          {2'b00, 16'h5556}, {2'b11, 16'h7FFF}, {2'b10, 16'h0002},
                          {2'b10, 16'hFFFF}};

   pipe_addsub #(.WIDTH(16), .STAGES(2)) u16 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(iv16), .in_ready(ir16),
      .a(a16), .b(b16), .cin(cin16), .sub(sub16),
`ifdef ADDSUB_SAT_EN
      .sat(sat16),
`endif
      .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(ovf16)
   );

   pipe_addsub #(.WIDTH(32), .STAGES(4)) u32 (
      .clk(clk), .rst_n(rst_n), .clr(1'b0), .in_valid(iv32), .in_ready(ir32),
      .a(a32), .b(b32), .cin(cin32), .sub(sub32),
`ifdef ADDSUB_SAT_EN
      .sat(sat32),
`endif
      .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(co32), .ovf(ovf32)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic flag(input string nm);
      checks++;
      errors++;
      $display("FAIL %s", nm);
   endtask

   always @(negedge clk) begin
      if (rst_n && mon16_en && ov16) begin
         if (q16.size() == 0) flag("u16_spurious_beat");
         else begin
            check("u16_result", {co16, ovf16, s16}, q16[0]);
            if (!or16) check("u16_in_ready_stalled", ir16, 1'b0);
            else void'(q16.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && ov32) begin
         if (!or32) stall32++;
         else if (q32.size() == 0) flag("u32_spurious_beat");
         else begin
            int lat, st;
            check("u32_result", {co32, ovf32, s32}, q32.pop_front());
            lat = cyc - acc_cyc.pop_front();
            st  = acc_stall.pop_front();
            if (st == stall32) check("u32_latency", lat, 4);
         end
      end
   end

   // called and returns just after a posedge; leaves iv16 asserted
   task automatic send16(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                         input logic vs, input logic vsat, input logic [17:0] exp, input bit track);
      int n = 0;
      a16 = va; b16 = vb; cin16 = vc; sub16 = vs; sat16 = vsat; iv16 = 1'b1;
      #1;
      while (!ir16 && n < 50) begin
         @(posedge clk); #2;
         n++;
      end
      if (!ir16) flag("u16_in_ready_timeout");
      @(posedge clk);
      if (track) q16.push_back(exp);
      #1;
   endtask

   task automatic run32(input int beats);
      int sent = 0;
      bit taken = 1'b0;
      logic [31:0] bp;
      logic        c0, ov;
      logic [32:0] r;
      while (sent < beats) begin
         @(posedge clk); #1;
         if (taken) iv32 = 1'b0;
         taken = 1'b0;
         or32 = ($urandom_range(0, 3) != 0);
         if (!iv32 && $urandom_range(0, 3) != 0) begin
            a32 = $urandom; b32 = $urandom;
            cin32 = $urandom_range(0, 1); sub32 = $urandom_range(0, 1);
            iv32 = 1'b1;
         end
         #1;
         if (iv32 && ir32) begin
            bp = sub32 ? ~b32 : b32;
            c0 = sub32 ? ~cin32 : cin32;
            r  = {1'b0, a32} + {1'b0, bp} + {32'd0, c0};
            ov = (a32[31] == bp[31]) && (r[31] != a32[31]);
            q32.push_back({r[32], ov, r[31:0]});
            acc_cyc.push_back(cyc);
            acc_stall.push_back(stall32);
            taken = 1'b1;
            sent++;
         end
      end
      @(posedge clk); #1;
      iv32 = 1'b0;
      or32 = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; clr = 1'b0;
      iv16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; sat16 = 1'b0;
      iv32 = 1'b0; or32 = 1'b1; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; sat32 = 1'b0;
      #1;
      check("rst_out_valid", ov16, 1'b0);
      check("rst_sum", s16, 16'h0);
      check("rst_cout", co16, 1'b0);
      check("rst_ovf", ovf16, 1'b0);
      check("rst_out_valid32", ov32, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 check("rst_in_ready", ir16, 1'b1);

      // first beat: latency of exactly two cycles
      @(posedge clk); #1;
      send16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, {2'b10, 16'h0000}, 1'b1);
      iv16 = 1'b0;
      check("lat_cycle1_valid", ov16, 1'b0);
      @(posedge clk); #1;
      check("lat_cycle2_valid", ov16, 1'b1);

      for (int i = 0; i < 7; i++) send16(ta[i], tb[i], tc[i], ts[i], 1'b0, te[i], 1'b1);
`ifdef ADDSUB_SAT_EN
      send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, {2'b01, 16'h7FFF}, 1'b1);
      send16(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, {2'b11, 16'h8000}, 1'b1);
      send16(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, {2'b11, 16'h8000}, 1'b1);
`endif
      iv16 = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      // back-to-back stream with a three-cycle downstream stall
      fork
         begin
            for (int i = 1; i <= 4; i++)
               send16(16'(i), 16'(i), 1'b0, 1'b0, 1'b0, {2'b00, 16'(2 * i)}, 1'b1);
            iv16 = 1'b0;
         end
         begin
            repeat (2) @(posedge clk);
            #1 or16 = 1'b0;
            repeat (3) @(posedge clk);
            #1 or16 = 1'b1;
         end
      join
      repeat (6) @(posedge clk);
      #1;

      // asynchronous reset with two beats in flight
      send16(16'h0011, 16'h0022, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      send16(16'h0033, 16'h0044, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      rst_n = 1'b0;
      iv16 = 1'b0;
      #1;
      check("async_rst_valid", ov16, 1'b0);
      check("async_rst_sum", s16, 16'h0);
      @(posedge clk); #1 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("post_rst_idle", ov16, 1'b0);
      end

      // synchronous flush; the beat offered alongside clr is dropped
      mon16_en = 1'b0;
      send16(16'h0101, 16'h0202, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      send16(16'h0303, 16'h0404, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      a16 = 16'h0009; b16 = 16'h0009; clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      iv16 = 1'b0;
      check("clr_valid", ov16, 1'b0);
      check("clr_in_ready", ir16, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("post_clr_idle", ov16, 1'b0);
      end
      mon16_en = 1'b1;
      send16(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, {2'b11, 16'h7FFF}, 1'b1);
      iv16 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("u16_drained", q16.size(), 0);

      run32(2000);
      for (int n = 0; n < 200 && q32.size() != 0; n++) @(posedge clk);
      #1;
      check("u32_drained", q32.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
